mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: issues aligned loads/stores, formats load data,
// and retires ALU/branch/misaligned ops straight into the M/W register.
module mem_stage_ctrl #(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [INSTR_TYPE_SZ-1:0]   in_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic [WORD_SIZE-1:0]       in_alu_result,
  input  logic [WORD_SIZE-1:0]       in_s2,
  input  logic [2:0]                 in_funct3,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WORD_SIZE-1:0]       mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_ack,
  input  logic [WORD_SIZE-1:0]       mem_rdata,
  input  logic                       out_stall,
  output logic                       out_valid,
  output logic [INSTR_TYPE_SZ-1:0]   out_type,
  output logic [WORD_SIZE-1:0]       out_pc,
  output logic [WORD_SIZE-1:0]       out_result,
  output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
  output logic                       out_misaligned
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [INSTR_TYPE_SZ-1:0] TY_LOAD =
    INSTR_TYPE_SZ'(1);
  localparam logic [INSTR_TYPE_SZ-1:0] TY_STORE =
    INSTR_TYPE_SZ'(2);

  logic [0:0]                 state_q, state_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0]       mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]                 mem_wstrb_q, mem_wstrb_d;

  logic                       out_valid_q, out_valid_d;
  logic [INSTR_TYPE_SZ-1:0]   out_type_q, out_type_d;
  logic [WORD_SIZE-1:0]       out_pc_q, out_pc_d;
  logic [WORD_SIZE-1:0]       out_result_q, out_result_d;
  logic [ROB_ENTRY_WIDTH-1:0] out_rob_q, out_rob_d;
  logic                       out_mis_q, out_mis_d;

  // Context of the in-flight access, used to format the ack data.
  logic [2:0]                 req_f3_q, req_f3_d;
  logic [1:0]                 req_off_q, req_off_d;
  logic [INSTR_TYPE_SZ-1:0]   req_type_q, req_type_d;
  logic [WORD_SIZE-1:0]       req_pc_q, req_pc_d;
  logic [ROB_ENTRY_WIDTH-1:0] req_rob_q, req_rob_d;

  logic                       is_ld, is_st, is_mem;
  logic                       mis, mis_acc, load_en, issue;
  logic [1:0]                 off;
  logic [3:0]                 st_wstrb;
  logic [WORD_SIZE-1:0]       st_wdata;
  logic [WORD_SIZE-1:0]       sh_b, sh_h, ld_res;
  logic                       stall_c;

  assign off     = in_alu_result[1:0];
  assign is_ld   = in_type == TY_LOAD;
  assign is_st   = in_type == TY_STORE;
  assign is_mem  = is_ld || is_st;
  assign load_en = !(out_valid_q && out_stall);

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      in_funct3[1:0] == 2'b00: mis = 1'b0;
      in_funct3[1:0] == 2'b01: mis = off[0];
      default:                 mis = |off;
    endcase
  end

  assign mis_acc = is_mem && mis;
  assign issue   = (state_q == IDLE) && in_valid
                && is_mem && !mis && load_en;

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = in_s2;
    unique case (1'b1)
      in_funct3[1:0] == 2'b00: begin
        st_wstrb = 4'b0001 << off;
        st_wdata = {(WORD_SIZE/8){in_s2[7:0]}};
      end
      in_funct3[1:0] == 2'b01: begin
        st_wstrb = 4'b0011 << off;
        st_wdata = {(WORD_SIZE/16){in_s2[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = in_s2;
      end
    endcase
  end

  assign sh_b = mem_rdata >> {req_off_q, 3'b000};
  assign sh_h = mem_rdata >> {req_off_q[1], 4'b0000};

  always_comb begin
    ld_res = mem_rdata;
    unique case (1'b1)
      req_f3_q[1:0] == 2'b00:
        ld_res = req_f3_q[2]
          ? {{(WORD_SIZE-8){1'b0}}, sh_b[7:0]}
          : {{(WORD_SIZE-8){sh_b[7]}}, sh_b[7:0]};
      req_f3_q[1:0] == 2'b01:
        ld_res = req_f3_q[2]
          ? {{(WORD_SIZE-16){1'b0}}, sh_h[15:0]}
          : {{(WORD_SIZE-16){sh_h[15]}}, sh_h[15:0]};
      default: ld_res = mem_rdata;
    endcase
  end

  always_comb begin
    stall_c = 1'b0;
    if (state_q == BUSY)
      stall_c = !mem_ack;
    else if (in_valid)
      stall_c = !load_en || (is_mem && !mis);
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    out_valid_d  = out_valid_q;
    out_type_d   = out_type_q;
    out_pc_d     = out_pc_q;
    out_result_d = out_result_q;
    out_rob_d    = out_rob_q;
    out_mis_d    = out_mis_q;
    req_f3_d     = req_f3_q;
    req_off_d    = req_off_q;
    req_type_d   = req_type_q;
    req_pc_d     = req_pc_q;
    req_rob_d    = req_rob_q;
    if (state_q == IDLE) begin
      if (load_en) begin
        out_valid_d = 1'b0;
        out_mis_d   = 1'b0;
        if (in_valid) begin
          unique case (1'b1)
            !is_mem: begin
              out_valid_d  = 1'b1;
              out_type_d   = in_type;
              out_pc_d     = in_pc;
              out_result_d = in_alu_result;
              out_rob_d    = in_rob_id;
            end
            mis_acc: begin
              out_valid_d  = 1'b1;
              out_type_d   = in_type;
              out_pc_d     = in_pc;
              out_result_d = in_alu_result;
              out_rob_d    = in_rob_id;
              out_mis_d    = 1'b1;
            end
            default: begin
              state_d     = BUSY;
              mem_req_d   = 1'b1;
              mem_we_d    = is_st;
              mem_addr_d  = {in_alu_result[WORD_SIZE-1:2], 2'b00};
              mem_wdata_d = st_wdata;
              mem_wstrb_d = is_st ? st_wstrb : 4'b0000;
              req_f3_d    = in_funct3;
              req_off_d   = off;
              req_type_d  = in_type;
              req_pc_d    = in_pc;
              req_rob_d   = in_rob_id;
            end
          endcase
        end
      end
    end else if (mem_ack) begin
      state_d      = IDLE;
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      mem_wstrb_d  = 4'b0000;
      out_valid_d  = 1'b1;
      out_type_d   = req_type_q;
      out_pc_d     = req_pc_q;
      out_rob_d    = req_rob_q;
      out_mis_d    = 1'b0;
      out_result_d = (req_type_q == TY_STORE) ? '0 : ld_res;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_type_q   <= '0;
      out_pc_q     <= '0;
      out_result_q <= '0;
      out_rob_q    <= '0;
      out_mis_q    <= 1'b0;
      req_f3_q     <= '0;
      req_off_q    <= '0;
      req_type_q   <= '0;
      req_pc_q     <= '0;
      req_rob_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      out_valid_q  <= out_valid_d;
      out_type_q   <= out_type_d;
      out_pc_q     <= out_pc_d;
      out_result_q <= out_result_d;
      out_rob_q    <= out_rob_d;
      out_mis_q    <= out_mis_d;
      req_f3_q     <= req_f3_d;
      req_off_q    <= req_off_d;
      req_type_q   <= req_type_d;
      req_pc_q     <= req_pc_d;
      req_rob_q    <= req_rob_d;
    end
  end

  assign stall          = stall_c;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wstrb      = mem_wstrb_q;
  assign out_valid      = out_valid_q;
  assign out_type       = out_type_q;
  assign out_pc         = out_pc_q;
  assign out_result     = out_result_q;
  assign out_rob_id     = out_rob_q;
  assign out_misaligned = out_mis_q;

endmodule
